ysyx_23060240_csr_ctrl: RTL and testbench
=========================================

# ysyx_23060240_csr_ctrl

Multi-cycle CSR access sequencer. It takes one decoded CSR/system instruction from the execute stage and issues the required read and write requests to the core's CSR register file over its read and write ports. It returns the old CSR value for rd and, for ecall/mret, a PC redirect target. It sits between the EXU and the CSR file.

## Interface
- XLEN, 32, datapath width
- MCAUSE_ECALL, 32'hb, cause code written on ecall (M-mode environment call)
- MSTATUS_TRAP, 32'h1800, value written to mstatus on trap entry (MPP=M)

- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_op  in  3  001 CSRRW, 010 CSRRS, 011 CSRRC, 100 ECALL, 101 MRET; any other value is illegal
- req_csr_addr  in  12  CSR address (CSRR* only)
- req_src  in  XLEN  rs1 value or zero-extended zimm
- req_pc  in  XLEN  PC of the instruction
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  XLEN  old CSR value (CSRR*); 0 otherwise
- rsp_redirect  out  1  PC redirect required (ECALL/MRET)
- rsp_target  out  XLEN  redirect target
- rsp_illegal  out  1  unsupported req_op
- r_csr_en  out  1  CSR read strobe
- r_csr_addr  out  12  CSR read address
- r_csr_data  in  XLEN  combinational read data from CSR file
- w_csr_en  out  1  CSR write strobe, one cycle per write
- w_csr_addr  out  12  CSR write address
- w_csr_data  out  XLEN  CSR write data

## Operation
- States: IDLE, READ, WRITE, T_EPC, T_CAUSE, T_STAT, T_VEC, RESP.
- Request accepted on req_valid && req_ready. The controller latches op, addr, src and pc.
- From IDLE: CSRR* or MRET → READ; ECALL → T_EPC; illegal → RESP with rsp_illegal=1 and no CSR access.
- READ: r_csr_en=1, r_csr_addr = latched addr (MRET: 12'h341). The controller latches r_csr_data as old.
  - MRET → RESP with redirect=1 and target=old.
  - CSRRS/CSRRC with src==0 → RESP, with no write.
  - Otherwise → WRITE.
- WRITE: w_csr_en=1, w_csr_addr=addr. Data: CSRRW src; CSRRS old|src; CSRRC old&~src. Next state RESP.
- T_EPC: write 12'h341 ← pc. T_CAUSE: write 12'h342 ← MCAUSE_ECALL. T_STAT: write 12'h300 ← MSTATUS_TRAP.
- T_VEC: read 12'h305, target = r_csr_data & ~32'h3 (direct mode only). Next state RESP with redirect=1.
- RESP: rsp_* outputs are driven from registers and stay stable while rsp_valid && !rsp_ready. On handshake the next state is IDLE.
- Strobes: r_csr_en and w_csr_en are never high in the same cycle. Outside their states they are 0, with addr/data 0.
- rsp_rdata = old for CSRR*, 0 for ECALL/MRET/illegal.

## Timing
- Reset (async, any state): state=IDLE, req_ready=1, and every other output 0. Latched fields clear to 0.
- Reset mid-sequence aborts the sequence. CSR writes already issued are not undone. No response is produced.
- Accept at cycle T. rsp_valid first rises at:
  - CSRRW, or CSRRS/C with a write: T+3
  - CSRRS/C with src==0: T+2
  - MRET: T+2
  - ECALL: T+5
  - illegal: T+1
- Read data is sampled in the same cycle as r_csr_en, because the CSR file read is combinational.
- The CSR file captures a write within the cycle w_csr_en is high. The value written in WRITE/T_* is visible to a read issued in any later cycle.
- req_ready=0 from T+1 until the cycle after the response handshake. Back-to-back throughput is one request per (latency+1) cycles minimum.
- A req_valid that arrives while busy is ignored and not latched. The requester holds it.

## Test plan
- CSRRW: mtvec=0x0, src=0x80000100 → T+1 read 0x305, T+2 write 0x305←0x80000100, T+3 rsp_rdata=0x0 and redirect=0.
- CSRRS then CSRRC on mstatus=0x1800 with src=0x8: write data 0x1808, then 0x1800. With src=0: no w_csr_en pulse and rsp at T+2.
- ECALL with pc=0x80000040, mtvec=0x80000103: writes mepc=0x80000040, mcause=0xb, mstatus=0x1800 in order. Then rsp_redirect=1 and target=0x80000100 at T+5.
- MRET with mepc=0x80000044: rsp at T+2 with redirect=1 and target=0x80000044. No w_csr_en for the whole sequence.
- Backpressure: hold rsp_ready=0 for 4 cycles → rsp_* stay stable, req_ready=0, and a new req_valid is not accepted. Illegal op 3'b111 → rsp_illegal=1 at T+1 with no CSR strobes.
- Reset asserted in T_CAUSE → outputs 0 immediately. Only the mepc write has occurred, no response is produced, and req_ready=1 after reset.

Source files
------------

// File: rtl/ysyx_23060240_csr_ctrl.sv
// Multi-cycle CSR access sequencer between the EXU and the CSR file.
// Turns one CSR/system instruction into a sequence of single-port CSR reads and writes.
module ysyx_23060240_csr_ctrl #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  MCAUSE_ECALL = 32'hb,
  parameter logic [XLEN-1:0]  MSTATUS_TRAP = 32'h1800
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [11:0]     req_csr_addr_i,
  input  logic [XLEN-1:0] req_src_i,
  input  logic [XLEN-1:0] req_pc_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_redirect_o,
  output logic [XLEN-1:0] rsp_target_o,
  output logic            rsp_illegal_o,
  output logic            r_csr_en_o,
  output logic [11:0]     r_csr_addr_o,
  input  logic [XLEN-1:0] r_csr_data_i,
  output logic            w_csr_en_o,
  output logic [11:0]     w_csr_addr_o,
  output logic [XLEN-1:0] w_csr_data_o
);

  localparam logic [2:0] OP_CSRRW = 3'b001;
  localparam logic [2:0] OP_CSRRS = 3'b010;
  localparam logic [2:0] OP_CSRRC = 3'b011;
  localparam logic [2:0] OP_ECALL = 3'b100;
  localparam logic [2:0] OP_MRET  = 3'b101;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] VEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_T_EPC, S_T_CAUSE, S_T_STAT, S_T_VEC, S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [11:0]       addr_q, addr_d;
  logic [XLEN-1:0]   src_q, src_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic              redirect_q, redirect_d;
  logic              illegal_q, illegal_d;
  logic              is_csrr;

  assign is_csrr = (op_q == OP_CSRRW) || (op_q == OP_CSRRS) || (op_q == OP_CSRRC);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    src_d        = src_q;
    pc_d         = pc_q;
    old_d        = old_q;
    target_d     = target_q;
    redirect_d   = redirect_q;
    illegal_d    = illegal_q;
    r_csr_en_o   = 1'b0;
    r_csr_addr_o = '0;
    w_csr_en_o   = 1'b0;
    w_csr_addr_o = '0;
    w_csr_data_o = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d       = req_op_i;
          addr_d     = req_csr_addr_i;
          src_d      = req_src_i;
          pc_d       = req_pc_i;
          old_d      = '0;
          target_d   = '0;
          redirect_d = 1'b0;
          illegal_d  = 1'b0;
          case (req_op_i)
            OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_MRET: state_d = S_READ;
            OP_ECALL: state_d = S_T_EPC;
            default: begin
              illegal_d = 1'b1;
              state_d   = S_RESP;
            end
          endcase
        end
      end
      S_READ: begin
        r_csr_en_o   = 1'b1;
        r_csr_addr_o = (op_q == OP_MRET) ? CSR_MEPC : addr_q;
        old_d        = r_csr_data_i;
        if (op_q == OP_MRET) begin
          redirect_d = 1'b1;
          target_d   = r_csr_data_i;
          state_d    = S_RESP;
        end else if (op_q != OP_CSRRW && src_q == '0) begin
          // set/clear with a zero mask is a pure read: no write side effects
          state_d = S_RESP;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        w_csr_en_o   = 1'b1;
        w_csr_addr_o = addr_q;
        case (op_q)
          OP_CSRRS: w_csr_data_o = old_q | src_q;
          OP_CSRRC: w_csr_data_o = old_q & ~src_q;
          default:  w_csr_data_o = src_q;
        endcase
        state_d = S_RESP;
      end
      S_T_EPC: begin
        w_csr_en_o   = 1'b1;
        w_csr_addr_o = CSR_MEPC;
        w_csr_data_o = pc_q;
        state_d      = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        w_csr_en_o   = 1'b1;
        w_csr_addr_o = CSR_MCAUSE;
        w_csr_data_o = MCAUSE_ECALL;
        state_d      = S_T_STAT;
      end
      S_T_STAT: begin
        w_csr_en_o   = 1'b1;
        w_csr_addr_o = CSR_MSTATUS;
        w_csr_data_o = MSTATUS_TRAP;
        state_d      = S_T_VEC;
      end
      S_T_VEC: begin
        // direct mode only: mode bits are dropped from the vector base
        r_csr_en_o   = 1'b1;
        r_csr_addr_o = CSR_MTVEC;
        target_d     = r_csr_data_i & VEC_MASK;
        redirect_d   = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      pc_q       <= '0;
      old_q      <= '0;
      target_q   <= '0;
      redirect_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      pc_q       <= pc_d;
      old_q      <= old_d;
      target_q   <= target_d;
      redirect_q <= redirect_d;
      illegal_q  <= illegal_d;
    end
  end

  assign req_ready_o    = (state_q == S_IDLE);
  assign rsp_valid_o    = (state_q == S_RESP);
  assign rsp_rdata_o    = (rsp_valid_o && is_csrr) ? old_q : '0;
  assign rsp_redirect_o = rsp_valid_o && redirect_q;
  assign rsp_target_o   = rsp_valid_o ? target_q : '0;
  assign rsp_illegal_o  = rsp_valid_o && illegal_q;

endmodule

// File: tb/tb_ysyx_23060240_csr_ctrl.sv
// Bench for the CSR sequencer: a CSR-file model drives reads, a transaction-level
// reference predicts writes, reads, latency and response for random and directed requests.
module tb_ysyx_23060240_csr_ctrl;

  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011, EC = 3'b100, MR = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [11:0] req_csr_addr = '0;
  logic [31:0] req_src = '0;
  logic [31:0] req_pc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_redirect;
  logic [31:0] rsp_target;
  logic        rsp_illegal;
  logic        r_csr_en;
  logic [11:0] r_csr_addr;
  logic [31:0] r_csr_data;
  logic        w_csr_en;
  logic [11:0] w_csr_addr;
  logic [31:0] w_csr_data;

  ysyx_23060240_csr_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_csr_addr_i(req_csr_addr), .req_src_i(req_src), .req_pc_i(req_pc),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_redirect_o(rsp_redirect), .rsp_target_o(rsp_target), .rsp_illegal_o(rsp_illegal),
    .r_csr_en_o(r_csr_en), .r_csr_addr_o(r_csr_addr), .r_csr_data_i(r_csr_data),
    .w_csr_en_o(w_csr_en), .w_csr_addr_o(w_csr_addr), .w_csr_data_o(w_csr_data)
  );

  always #5 clk = ~clk;

  // CSR file seen by the DUT, plus the reference's own view of it
  logic [31:0] csr_mem [4096];
  logic [31:0] ref_mem [4096];
  assign r_csr_data = csr_mem[r_csr_addr];

  logic [43:0] wlog[$];
  logic [11:0] rlog[$];
  int overlap = 0;

  always @(posedge clk) begin
    if (w_csr_en) begin
      csr_mem[w_csr_addr] = w_csr_data;
      wlog.push_back({w_csr_addr, w_csr_data});
    end
    if (r_csr_en) rlog.push_back(r_csr_addr);
    if (r_csr_en && w_csr_en) overlap++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setcsr(input logic [11:0] a, input logic [31:0] v);
    csr_mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic run(input logic [2:0] op, input logic [11:0] a, input logic [31:0] src,
                     input logic [31:0] pc, input int hold, input string tag);
    logic [43:0] exp_w[$];
    logic [11:0] exp_r[$];
    int          lat = 1;
    int          n = 0;
    logic [31:0] e_rdata = '0;
    logic [31:0] e_tgt = '0;
    logic        e_red = 1'b0;
    logic        e_ill = 1'b0;
    logic [31:0] old;
    logic [66:0] snap;
    // reference: what the instruction means, one transaction at a time
    case (op)
      RW, RS, RC: begin
        old = ref_mem[a];
        exp_r.push_back(a);
        e_rdata = old;
        if (op == RW || src != 0) begin
          ref_mem[a] = (op == RW) ? src : (op == RS) ? (old | src) : (old & ~src);
          exp_w.push_back({a, ref_mem[a]});
          lat = 3;
        end else lat = 2;
      end
      EC: begin
        exp_w.push_back({12'h341, pc});
        exp_w.push_back({12'h342, 32'hb});
        exp_w.push_back({12'h300, 32'h1800});
        ref_mem[12'h341] = pc;
        ref_mem[12'h342] = 32'hb;
        ref_mem[12'h300] = 32'h1800;
        exp_r.push_back(12'h305);
        e_tgt = {ref_mem[12'h305][31:2], 2'b00};
        e_red = 1'b1;
        lat = 5;
      end
      MR: begin
        exp_r.push_back(12'h341);
        e_tgt = ref_mem[12'h341];
        e_red = 1'b1;
        lat = 2;
      end
      default: begin
        e_ill = 1'b1;
        lat = 1;
      end
    endcase
    wlog.delete();
    rlog.delete();
    req_valid = 1'b1; req_op = op; req_csr_addr = a; req_src = src; req_pc = pc;
    chk({tag, ".ready"}, {63'b0, req_ready}, 64'd1);
    while (n < 12) begin
      @(posedge clk); #1;
      n++;
      req_valid = 1'b0;
      if (rsp_valid) break;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".rdata"}, rsp_rdata, e_rdata);
    chk({tag, ".redirect"}, {63'b0, rsp_redirect}, {63'b0, e_red});
    chk({tag, ".target"}, rsp_target, e_tgt);
    chk({tag, ".illegal"}, {63'b0, rsp_illegal}, {63'b0, e_ill});
    snap = {rsp_valid, rsp_redirect, rsp_illegal, rsp_rdata, rsp_target};
    // backpressure with a competing request that must not be taken
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_op = RW; req_csr_addr = 12'h340; req_src = $urandom;
      @(posedge clk); #1;
      chk({tag, ".hold"}, {snap[66:32], 29'b0}, {rsp_valid, rsp_redirect, rsp_illegal, rsp_rdata, 29'b0});
      chk({tag, ".hold_tgt"}, snap[31:0], rsp_target);
      chk({tag, ".hold_busy"}, {63'b0, req_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk({tag, ".done"}, {62'b0, rsp_valid, req_ready}, 64'd1);
    chk({tag, ".nwr"}, wlog.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wlog.size(); i++)
      chk({tag, ".wr"}, wlog[i], exp_w[i]);
    chk({tag, ".nrd"}, rlog.size(), exp_r.size());
    for (int i = 0; i < exp_r.size() && i < rlog.size(); i++)
      chk({tag, ".rd"}, rlog[i], exp_r[i]);
  endtask

  logic [11:0] alist [5] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};
  logic [2:0]  oplist [8] = '{RW, RS, RC, EC, MR, RS, 3'b111, 3'b000};

  initial begin
    int hi;
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = '0;
      ref_mem[i] = '0;
    end
    #1;
    chk("reset", {rsp_valid, r_csr_en, w_csr_en, rsp_redirect, rsp_illegal, req_ready},
        {5'b0, 1'b1});
    chk("reset_data", {rsp_rdata, rsp_target}, 64'd0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // directed
    setcsr(12'h305, 32'h0);
    run(RW, 12'h305, 32'h80000100, 32'h0, 0, "csrrw_mtvec");
    setcsr(12'h300, 32'h1800);
    run(RS, 12'h300, 32'h8, 32'h0, 0, "csrrs_mstatus");
    run(RC, 12'h300, 32'h8, 32'h0, 1, "csrrc_mstatus");
    run(RS, 12'h300, 32'h0, 32'h0, 0, "csrrs_zero");
    run(RC, 12'h300, 32'h0, 32'h0, 0, "csrrc_zero");
    setcsr(12'h305, 32'h80000103);
    run(EC, 12'h000, 32'h0, 32'h80000040, 0, "ecall");
    setcsr(12'h341, 32'h80000044);
    run(MR, 12'h000, 32'h0, 32'h0, 0, "mret");
    run(RW, 12'h340, 32'hdeadbeef, 32'h0, 4, "backpressure");
    run(3'b111, 12'h300, 32'h5, 32'h0, 0, "illegal");

    // random
    for (int k = 0; k < 200; k++) begin
      logic [31:0] s;
      s = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      run(oplist[$urandom_range(0, 7)], alist[$urandom_range(0, 4)], s,
          {$urandom_range(0, 32'h3fff_ffff), 2'b00}, $urandom_range(0, 3), "rand");
    end

    // reset while in the middle of the trap-entry sequence
    setcsr(12'h305, 32'h80000200);
    wlog.delete();
    req_valid = 1'b1; req_op = EC; req_pc = 32'h80000080;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {rsp_valid, r_csr_en, w_csr_en, rsp_redirect, rsp_illegal, req_ready},
        {5'b0, 1'b1});
    chk("rst_mid_data", {w_csr_data, rsp_target}, 64'd0);
    chk("rst_mid_nwr", wlog.size(), 1);
    if (wlog.size() > 0) chk("rst_mid_wr", wlog[0], {12'h341, 32'h80000080});
    ref_mem[12'h341] = 32'h80000080;
    @(negedge clk) rst_n = 1'b1;
    hi = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rsp_valid || w_csr_en || r_csr_en) hi++;
    end
    chk("rst_quiet", hi, 0);
    chk("rst_ready", {63'b0, req_ready}, 64'd1);
    chk("rst_total_wr", wlog.size(), 1);
    run(MR, 12'h000, 32'h0, 32'h0, 0, "post_reset_mret");

    for (int i = 0; i < 5; i++) chk("final_csr", csr_mem[alist[i]], ref_mem[alist[i]]);
    chk("strobe_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
